// File: rtl/chrono_lap_ctrl_if.sv
// Lap RAM port bundle: the write port carries stored laps, the read port serves recalls.
interface chrono_lap_ctrl_if #(
   parameter int CNT_WIDTH = 16,
   parameter int ADDR_SIZE = 4
);
   logic                 wr_en;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [CNT_WIDTH-1:0] wr_data;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [CNT_WIDTH-1:0] rd_data;

   // Controller side drives the addresses and write data
   modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
   // RAM side answers reads
   modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/chrono_lap_ctrl.sv
// Chronometer controller: up/down count at a divided tick, lap capture into an
// external RAM and single-outstanding lap recall.
module chrono_lap_ctrl #(
   parameter int TICK_DIV  = 5000000,
   parameter int CNT_WIDTH = 16,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_d_i,
   input  logic                 stop_d_i,
   input  logic                 restart_d_i,
   input  logic                 lap_d_i,
   input  logic                 dir_i,
   input  logic [CNT_WIDTH-1:0] load_val_i,
   input  logic                 recall_i,
   input  logic [ADDR_SIZE-1:0] recall_idx_i,
   output logic [CNT_WIDTH-1:0] value_o,
   output logic                 running_o,
   output logic                 expired_o,
   output logic                 wrap_o,
   output logic [CNT_WIDTH-1:0] recall_value_o,
   output logic                 recall_valid_o,
   output logic [ADDR_SIZE:0]   lap_count_o,
   output logic                 lap_full_o,
   output logic                 lap_ovf_o,
   chrono_lap_ctrl_if.master    ram
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]      PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [ADDR_SIZE:0] DEPTH   = {1'b1, {ADDR_SIZE{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_EXP   = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 dir_q, dir_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic [CNT_WIDTH-1:0] value_q, value_d;
   logic                 wrap_q, wrap_d;
   logic                 running_q, expired_q;
   logic [ADDR_SIZE:0]   lap_cnt_q, lap_cnt_d;
   logic                 lap_full_q, lap_ovf_q, lap_ovf_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                 pend_q, rec_vld_q;
   logic [ADDR_SIZE-1:0] rd_addr_q;
   logic [CNT_WIDTH-1:0] rec_val_q;
   logic                 cnt_en;

   // Restart overrides everything; otherwise a command needs exactly one pulse
   logic one_cmd, cmd_restart, cmd_start, cmd_stop, cmd_lap;
   assign one_cmd     = ({1'b0, start_d_i} + {1'b0, stop_d_i} + {1'b0, lap_d_i}) == 2'd1;
   assign cmd_restart = restart_d_i;
   assign cmd_start   = !restart_d_i && one_cmd && start_d_i;
   assign cmd_stop    = !restart_d_i && one_cmd && stop_d_i;
   assign cmd_lap     = !restart_d_i && one_cmd && lap_d_i;

   // Mode FSM, prescaler and counter step
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pre_d   = pre_q;
      value_d = value_q;
      wrap_d  = 1'b0;
      cnt_en  = 1'b0;
      if (cmd_restart) begin
         state_d = S_IDLE;
         value_d = '0;
         pre_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: if (cmd_start) begin
               // The start cycle is the first prescaler cycle of the run
               dir_d = dir_i;
               pre_d = PW'(1);
               if (!dir_i) begin
                  value_d = '0;
                  state_d = S_RUN;
               end else if (load_val_i == '0) begin
                  value_d = '0;
                  pre_d   = '0;
                  state_d = S_EXP;
               end else begin
                  value_d = load_val_i;
                  state_d = S_RUN;
               end
            end
            S_RUN:   if (cmd_stop) state_d = S_PAUSE; else cnt_en = 1'b1;
            S_PAUSE: if (cmd_start) begin state_d = S_RUN; cnt_en = 1'b1; end
            default: value_d = '0;
         endcase
      end
      if (cnt_en) begin
         if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (dir_q) begin
               value_d = value_q - CNT_WIDTH'(1);
               if (value_d == '0) begin
                  state_d = S_EXP;
                  pre_d   = '0;
               end
            end else begin
               value_d = value_q + CNT_WIDTH'(1);
               wrap_d  = (value_q == '1);
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   // Lap capture: data is the count as registered before this edge's step
   always_comb begin
      lap_cnt_d = lap_cnt_q;
      lap_ovf_d = lap_ovf_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (cmd_restart) begin
         lap_cnt_d = '0;
         lap_ovf_d = 1'b0;
      end else if (cmd_lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
         if (lap_cnt_q == DEPTH) begin
            lap_ovf_d = 1'b1;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = lap_cnt_q[ADDR_SIZE-1:0];
            wr_data_d = value_q;
            lap_cnt_d = lap_cnt_q + (ADDR_SIZE+1)'(1);
         end
      end
   end

   // Counter, status flags and lap write port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dir_q      <= 1'b0;
         pre_q      <= '0;
         value_q    <= '0;
         wrap_q     <= 1'b0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         lap_cnt_q  <= '0;
         lap_full_q <= 1'b0;
         lap_ovf_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pre_q      <= pre_d;
         value_q    <= value_d;
         wrap_q     <= wrap_d;
         running_q  <= (state_d == S_RUN);
         expired_q  <= (state_d == S_EXP);
         lap_cnt_q  <= lap_cnt_d;
         lap_full_q <= (lap_cnt_d == DEPTH);
         lap_ovf_q  <= lap_ovf_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Recall: present the address the cycle after the pulse, capture the RAM
   // word at the end of that cycle; new requests are dropped while pending
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= 1'b0;
         rd_addr_q <= '0;
         rec_val_q <= '0;
         rec_vld_q <= 1'b0;
      end else begin
         rec_vld_q <= 1'b0;
         if (pend_q) begin
            rec_val_q <= ram.rd_data;
            rec_vld_q <= 1'b1;
            pend_q    <= 1'b0;
         end else if (recall_i) begin
            rd_addr_q <= recall_idx_i;
            pend_q    <= 1'b1;
         end
      end
   end

   assign value_o        = value_q;
   assign running_o      = running_q;
   assign expired_o      = expired_q;
   assign wrap_o         = wrap_q;
   assign recall_value_o = rec_val_q;
   assign recall_valid_o = rec_vld_q;
   assign lap_count_o    = lap_cnt_q;
   assign lap_full_o     = lap_full_q;
   assign lap_ovf_o      = lap_ovf_q;
   assign ram.wr_en      = wr_en_q;
   assign ram.wr_addr    = wr_addr_q;
   assign ram.wr_data    = wr_data_q;
   assign ram.rd_addr    = rd_addr_q;
endmodule

// File: tb/tb_chrono_lap_ctrl.sv
// Bench for chrono_lap_ctrl with TICK_DIV=4, CNT_WIDTH=8, ADDR_SIZE=2.
module tb_chrono_lap_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_d = 0, stop_d = 0, restart_d = 0, lap_d = 0, dir = 0;
   logic [7:0] load_val = 0;
   logic       recall = 0;
   logic [1:0] recall_idx = 0;
   logic [7:0] value, recall_value;
   logic       running, expired, wrap, recall_valid, lap_full, lap_ovf;
   logic [2:0] lap_count;
   int         cyc = 0;
   int         total = 0, bad = 0;

   chrono_lap_ctrl_if #(.CNT_WIDTH(8), .ADDR_SIZE(2)) bus ();

   chrono_lap_ctrl #(.TICK_DIV(4), .CNT_WIDTH(8), .ADDR_SIZE(2)) dut (
      .clk(clk), .rst(rst),
      .start_d_i(start_d), .stop_d_i(stop_d), .restart_d_i(restart_d), .lap_d_i(lap_d),
      .dir_i(dir), .load_val_i(load_val), .recall_i(recall), .recall_idx_i(recall_idx),
      .value_o(value), .running_o(running), .expired_o(expired), .wrap_o(wrap),
      .recall_value_o(recall_value), .recall_valid_o(recall_valid),
      .lap_count_o(lap_count), .lap_full_o(lap_full), .lap_ovf_o(lap_ovf),
      .ram(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lap RAM model: word for rd_addr is visible while rd_addr is presented
   logic [7:0] mem [4];
   always @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
   assign bus.rd_data = mem[bus.rd_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic s, input logic p, input logic r, input logic l);
      start_d = s; stop_d = p; restart_d = r; lap_d = l;
      tick();
      start_d = 0; stop_d = 0; restart_d = 0; lap_d = 0;
   endtask

   // Scoreboards: expected writes and recalls with the cycle they must appear in
   typedef struct { logic [1:0] addr; logic [7:0] data; int c; } wr_exp_t;
   typedef struct { logic [7:0] val; int c; } rc_exp_t;
   wr_exp_t wq[$];
   rc_exp_t rq[$];
   wr_exp_t we;
   rc_exp_t re;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en) begin
            if (wq.size() == 0) chk("wr_en unexpected", 1, 0);
            else begin
               we = wq.pop_front();
               chk("wr_addr", {30'd0, bus.wr_addr}, {30'd0, we.addr});
               chk("wr_data", {24'd0, bus.wr_data}, {24'd0, we.data});
               chk("wr_cycle", cyc, we.c);
            end
         end
         if (recall_valid) begin
            if (rq.size() == 0) chk("recall_valid unexpected", 1, 0);
            else begin
               re = rq.pop_front();
               chk("recall_value", {24'd0, recall_value}, {24'd0, re.val});
               chk("recall_cycle", cyc, re.c);
            end
         end
      end
   end

   typedef struct {
      logic start, stop, restart, lap, dir;
      logic [7:0] load;
      int   wait_n;
      logic [7:0] e_value;
      logic e_run, e_exp;
      logic [2:0] e_laps;
   } vec_t;
   localparam int NV = 15;
   vec_t tbl[NV];

   initial begin
      //           st sp rs lp dr load   wait  value  run exp laps
      tbl[0]  = '{1, 0, 0, 0, 0, 8'd0, 40, 8'd10, 1, 0, 3'd0};
      tbl[1]  = '{0, 1, 0, 0, 0, 8'd0, 10, 8'd10, 0, 0, 3'd0};
      tbl[2]  = '{1, 0, 0, 0, 1, 8'd9,  1, 8'd10, 1, 0, 3'd0};
      tbl[3]  = '{0, 0, 0, 0, 0, 8'd0,  0, 8'd11, 1, 0, 3'd0};
      tbl[4]  = '{1, 1, 0, 0, 0, 8'd0,  0, 8'd11, 1, 0, 3'd0};
      tbl[5]  = '{1, 0, 1, 0, 0, 8'd0,  2, 8'd0,  0, 0, 3'd0};
      tbl[6]  = '{1, 0, 0, 0, 1, 8'd3, 11, 8'd0,  0, 1, 3'd0};
      tbl[7]  = '{1, 0, 0, 0, 0, 8'd0,  3, 8'd0,  0, 1, 3'd0};
      tbl[8]  = '{0, 1, 0, 0, 0, 8'd0,  3, 8'd0,  0, 1, 3'd0};
      tbl[9]  = '{0, 0, 0, 1, 0, 8'd0,  2, 8'd0,  0, 1, 3'd0};
      tbl[10] = '{0, 0, 1, 0, 0, 8'd0,  0, 8'd0,  0, 0, 3'd0};
      tbl[11] = '{0, 0, 0, 1, 0, 8'd0,  1, 8'd0,  0, 0, 3'd0};
      tbl[12] = '{1, 0, 0, 1, 0, 8'd0,  1, 8'd0,  0, 0, 3'd0};
      tbl[13] = '{1, 0, 0, 0, 1, 8'd5,  4, 8'd4,  1, 0, 3'd0};
      tbl[14] = '{0, 0, 1, 0, 0, 8'd0,  1, 8'd0,  0, 0, 3'd0};

      // Reset state
      repeat (3) tick();
      rst = 0;
      tick();
      chk("rst value", value, 0);
      chk("rst running", running, 0);
      chk("rst expired", expired, 0);
      chk("rst wrap", wrap, 0);
      chk("rst lap_count", lap_count, 0);
      chk("rst lap_full", lap_full, 0);
      chk("rst lap_ovf", lap_ovf, 0);
      chk("rst wr_en", bus.wr_en, 0);
      chk("rst recall_valid", recall_valid, 0);

      // Command decode and counting table
      for (int i = 0; i < NV; i++) begin
         dir = tbl[i].dir; load_val = tbl[i].load;
         pulse(tbl[i].start, tbl[i].stop, tbl[i].restart, tbl[i].lap);
         repeat (tbl[i].wait_n) tick();
         chk($sformatf("row%0d value", i), value, tbl[i].e_value);
         chk($sformatf("row%0d running", i), running, tbl[i].e_run);
         chk($sformatf("row%0d expired", i), expired, tbl[i].e_exp);
         chk($sformatf("row%0d lap_count", i), lap_count, tbl[i].e_laps);
      end

      // Five laps, each in the cycle of a step edge (value i before the step)
      dir = 0;
      pulse(1, 0, 0, 0);
      repeat (6) tick();
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("lap%0d value", i), value, i);
         if (i <= 4) wq.push_back('{addr: 2'(i - 1), data: 8'(i), c: cyc + 1});
         pulse(0, 0, 0, 1);
         if (i == 4) begin
            chk("lap4 lap_full", lap_full, 1);
            chk("lap4 lap_ovf", lap_ovf, 0);
         end
         repeat (3) tick();
      end
      chk("laps lap_count", lap_count, 4);
      chk("laps lap_full", lap_full, 1);
      chk("laps lap_ovf", lap_ovf, 1);

      // Recall idx 2, a dropped recall at +1, then an accepted one at +2
      recall = 1; recall_idx = 2;
      rq.push_back('{val: 8'd3, c: cyc + 2});
      tick();
      chk("recall rd_addr", bus.rd_addr, 2);
      chk("recall early valid", recall_valid, 0);
      recall_idx = 0;
      tick();
      chk("recall value direct", recall_value, 3);
      recall_idx = 1;
      rq.push_back('{val: 8'd2, c: cyc + 2});
      tick();
      recall = 0;
      chk("recall2 rd_addr", bus.rd_addr, 1);
      repeat (2) tick();

      // Restart clears lap bookkeeping
      pulse(0, 0, 1, 0);
      chk("restart lap_count", lap_count, 0);
      chk("restart lap_full", lap_full, 0);
      chk("restart lap_ovf", lap_ovf, 0);
      chk("restart running", running, 0);

      // rst aborts a pending recall
      recall = 1; recall_idx = 3;
      tick();
      recall = 0; rst = 1;
      tick();
      rst = 0;
      chk("rst abort valid", recall_valid, 0);
      tick();
      chk("rst abort valid+1", recall_valid, 0);

      // Up-count wrap from 255
      dir = 0;
      pulse(1, 0, 0, 0);
      repeat (1019) tick();
      chk("wrap pre value", value, 255);
      chk("wrap pre pulse", wrap, 0);
      repeat (3) tick();
      chk("wrap hold value", value, 255);
      tick();
      chk("wrap value", value, 0);
      chk("wrap pulse", wrap, 1);
      tick();
      chk("wrap pulse end", wrap, 0);
      chk("wrap value hold", value, 0);

      repeat (3) tick();
      chk("wr scoreboard drained", wq.size(), 0);
      chk("recall scoreboard drained", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
